// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and constants for the CPU run/halt/step sequencer
//
// Purpose: state encoding, HLT opcode default, opcode field width, retired
// counter width and a saturating increment helper.
// Ports: none (package).
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'b00,
    ST_HALTED     = 2'b01,
    ST_RUNNING    = 2'b10,
    ST_STEPPING   = 2'b11
  } state_t;

  localparam int                  OPCODE_W       = 4;
  localparam int                  RETIRED_W      = 16;
  localparam logic [OPCODE_W-1:0] HLT_OPCODE_DEF = 4'hF;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [RETIRED_W-1:0] sat_inc(input logic [RETIRED_W-1:0] v);
    return (v == {RETIRED_W{1'b1}}) ? v : v + RETIRED_W'(1);
  endfunction

endpackage

// File: rtl/ce_divider.sv
// rtl/ce_divider.sv - free-running 2^DIV_LOG2 divider with clear, enable and terminal-count flag
//
// Purpose: paces core clock enables; o_TC is high while the count sits at
// its last value (2^DIV_LOG2-1).
// Ports:
//   i_CLK  clock
//   i_RST  asynchronous active-high reset (count -> 0)
//   i_EN   advance the count this cycle
//   i_CLR  synchronous clear, wins over i_EN
//   o_TC   terminal count reached
module ce_divider #(
  parameter int DIV_LOG2 = 5
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_EN,
  input  logic i_CLR,
  output logic o_TC
);

  logic [DIV_LOG2-1:0] cnt_q;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      cnt_q <= '0;
    end else if (i_CLR) begin
      cnt_q <= '0;
    end else if (i_EN) begin
      cnt_q <= cnt_q + DIV_LOG2'(1);
    end
  end

  assign o_TC = (cnt_q == {DIV_LOG2{1'b1}});

endmodule

// File: rtl/cpu_step_controller.sv
// rtl/cpu_step_controller.sv - run/halt/single-step sequencer issuing core clock enables
//
// Purpose: holds the core in reset after power-up, then paces one-cycle
// clock enables every 2^DIV_LOG2 cycles while running or stepping, stopping
// on HLT opcodes, PC breakpoints or a halt request.
// Optional: define STEP_CTRL_TRACE_EN to add o_LAST_PC / o_TRACE_VLD.
// Ports:
//   i_CLK, i_RST            clock, asynchronous active-high reset
//   i_RUN, i_HALT, i_STEP   one-cycle control pulses (HALT > STEP > RUN)
//   i_BP_EN, i_BP_ADDR      breakpoint enable and address
//   i_PC, i_INSTR           current core PC and instruction
//   o_CPU_CE                one-cycle core clock enable
//   o_CPU_RST               core reset, active-high
//   o_STATE                 00 reset hold, 01 halted, 10 running, 11 stepping
//   o_BP_HIT                sticky breakpoint flag
//   o_LAST_PC, o_TRACE_VLD  PC at last CE, pulse one cycle after CE (trace build)
//   o_RETIRED               saturating count of issued enables
module cpu_step_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int                  DIV_LOG2   = 5,
  parameter int                  PC_W       = 8,
  parameter int                  INSTR_W    = 16,
  parameter logic [OPCODE_W-1:0] HLT_OPCODE = HLT_OPCODE_DEF,
  parameter int                  RST_HOLD   = 4,
  parameter int                  AUTO_RUN   = 0
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic                 i_RUN,
  input  logic                 i_HALT,
  input  logic                 i_STEP,
  input  logic                 i_BP_EN,
  input  logic [PC_W-1:0]      i_BP_ADDR,
  input  logic [PC_W-1:0]      i_PC,
  input  logic [INSTR_W-1:0]   i_INSTR,
  output logic                 o_CPU_CE,
  output logic                 o_CPU_RST,
  output logic [1:0]           o_STATE,
  output logic                 o_BP_HIT,
`ifdef STEP_CTRL_TRACE_EN
  output logic [PC_W-1:0]      o_LAST_PC,
  output logic                 o_TRACE_VLD,
`endif
  output logic [RETIRED_W-1:0] o_RETIRED
);

  localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  state_t                 state_q, state_d;
  logic                   ce_q, ce_d;
  logic                   cpu_rst_q, cpu_rst_d;
  logic                   bp_hit_q, bp_hit_d;
  logic                   resume_q, resume_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [RETIRED_W-1:0]   retired_q, retired_d;

  logic tc;
  logic run_mode;
  logic ce_issue;
  logic hlt_op;
  logic bp_match;
  logic div_clr;
  logic unused_instr_bits;

  assign run_mode = (state_q == ST_RUNNING) || (state_q == ST_STEPPING);
  // The enable is registered; only a same-cycle HALT can suppress it.
  assign ce_issue = ce_q & ~i_HALT;
  assign hlt_op   = (i_INSTR[INSTR_W-1 -: OPCODE_W] == HLT_OPCODE);
  assign bp_match = i_BP_EN && (i_PC == i_BP_ADDR);
  // Any exit from running/stepping discards the partial count.
  assign div_clr  = (state_d != ST_RUNNING) && (state_d != ST_STEPPING);
  assign unused_instr_bits = ^i_INSTR[INSTR_W-OPCODE_W-1:0];

  ce_divider #(
    .DIV_LOG2 (DIV_LOG2)
  ) u_ce_divider (
    .i_CLK (i_CLK),
    .i_RST (i_RST),
    .i_EN  (run_mode),
    .i_CLR (div_clr),
    .o_TC  (tc)
  );

  always_comb begin
    state_d   = state_q;
    ce_d      = 1'b0;
    bp_hit_d  = bp_hit_q;
    resume_d  = resume_q;
    hold_d    = hold_q;
    retired_d = retired_q;

    if (ce_issue) begin
      retired_d = sat_inc(retired_q);
      resume_d  = 1'b0;
    end

    case (state_q)
      ST_RESET_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = (AUTO_RUN != 0) ? ST_RUNNING : ST_HALTED;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_HALTED: begin
        // Resume flag lets the instruction sitting on a breakpoint execute once.
        if (i_STEP) begin
          state_d  = ST_STEPPING;
          resume_d = 1'b1;
          bp_hit_d = 1'b0;
        end else if (i_RUN) begin
          state_d  = ST_RUNNING;
          resume_d = 1'b1;
          bp_hit_d = 1'b0;
        end
      end
      ST_RUNNING, ST_STEPPING: begin
        if (i_HALT) begin
          state_d = ST_HALTED;
        end else if (ce_q && (state_q == ST_STEPPING)) begin
          state_d = ST_HALTED;
        end else if (tc) begin
          if (hlt_op) begin
            state_d = ST_HALTED;
          end else if (bp_match && !resume_q) begin
            state_d  = ST_HALTED;
            bp_hit_d = 1'b1;
          end else begin
            ce_d = 1'b1;
          end
        end
      end
      default: state_d = ST_HALTED;
    endcase

    cpu_rst_d = (state_d == ST_RESET_HOLD);
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q   <= ST_RESET_HOLD;
      ce_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
      bp_hit_q  <= 1'b0;
      resume_q  <= 1'b0;
      hold_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ce_q      <= ce_d;
      cpu_rst_q <= cpu_rst_d;
      bp_hit_q  <= bp_hit_d;
      resume_q  <= resume_d;
      hold_q    <= hold_d;
      retired_q <= retired_d;
    end
  end

  assign o_CPU_CE  = ce_issue;
  assign o_CPU_RST = cpu_rst_q;
  assign o_STATE   = state_q;
  assign o_BP_HIT  = bp_hit_q;
  assign o_RETIRED = retired_q;

`ifdef STEP_CTRL_TRACE_EN
  logic [PC_W-1:0] last_pc_q;
  logic            trace_vld_q;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      last_pc_q   <= '0;
      trace_vld_q <= 1'b0;
    end else begin
      trace_vld_q <= ce_issue;
      if (ce_issue) begin
        last_pc_q <= i_PC;
      end
    end
  end

  assign o_LAST_PC   = last_pc_q;
  assign o_TRACE_VLD = trace_vld_q;
`else
  // Trace build disabled: no trace registers or ports.
`endif

endmodule

// File: tb/tb_cpu_step_controller.sv
// tb/tb_cpu_step_controller.sv - self-checking bench for cpu_step_controller
module tb_cpu_step_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        halt = 1'b0;
  logic        step = 1'b0;
  logic        bp_en = 1'b0;
  logic [7:0]  bp_addr = 8'd0;
  logic [7:0]  pc;
  logic [15:0] instr;
  logic        ce;
  logic        cpu_rst;
  logic [1:0]  state;
  logic        bp_hit;
  logic [15:0] retired;

  int          n_total = 0;
  int          n_bad = 0;
  int          cyc_no = 0;
  bit          chk_on = 1'b0;
  int          instr_mode = 0;
  logic [15:0] instr_rand = 16'd0;

  // model state: mode 0 hold, 1 halted, 2 running, 3 stepping
  int m_mode = 0;
  int m_hold = 0;
  int m_tc = 0;
  int m_ret = 0;
  bit m_ce = 1'b0;
  bit m_bp = 1'b0;
  bit m_res = 1'b0;
  bit m_issued;
  bit m_nxt_ce;

  cpu_step_controller #(
    .DIV_LOG2   (5),
    .PC_W       (8),
    .INSTR_W    (16),
    .HLT_OPCODE (4'hF),
    .RST_HOLD   (4),
    .AUTO_RUN   (0)
  ) dut (
    .i_CLK     (clk),
    .i_RST     (rst),
    .i_RUN     (run),
    .i_HALT    (halt),
    .i_STEP    (step),
    .i_BP_EN   (bp_en),
    .i_BP_ADDR (bp_addr),
    .i_PC      (pc),
    .i_INSTR   (instr),
    .o_CPU_CE  (ce),
    .o_CPU_RST (cpu_rst),
    .o_STATE   (state),
    .o_BP_HIT  (bp_hit),
    .o_RETIRED (retired)
  );

  always #5 clk = ~clk;

  assign instr = (instr_mode == 1) ? ((pc == 8'd3) ? 16'hF000 : 16'h1000) :
                 (instr_mode == 2) ? instr_rand : 16'h2ABC;

  // core: PC advances on every enable, cleared while held in reset
  always @(posedge clk or posedge rst) begin
    if (rst)          pc <= 8'd0;
    else if (cpu_rst) pc <= 8'd0;
    else if (ce)      pc <= pc + 8'd1;
  end

  always @(posedge clk) cyc_no <= cyc_no + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: decisions scheduled at absolute cycle numbers
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_hold = 0; m_tc = 0; m_ret = 0;
      m_ce = 1'b0; m_bp = 1'b0; m_res = 1'b0;
    end else begin
      m_issued = m_ce && !halt;
      if (m_issued) begin
        if (m_ret < 65535) m_ret = m_ret + 1;
        m_res = 1'b0;
      end
      m_nxt_ce = 1'b0;
      if (m_mode == 0) begin
        m_hold = m_hold + 1;
        if (m_hold >= 4) m_mode = 1;
      end else if (m_mode == 1) begin
        if (step || run) begin
          m_mode = step ? 3 : 2;
          m_tc = cyc_no + 32;
          m_res = 1'b1;
          m_bp = 1'b0;
        end
      end else begin
        if (halt) m_mode = 1;
        else if (m_issued && m_mode == 3) m_mode = 1;
        else if (cyc_no == m_tc) begin
          if (instr[15:12] == 4'hF) m_mode = 1;
          else if (bp_en && pc == bp_addr && !m_res) begin
            m_mode = 1;
            m_bp = 1'b1;
          end else begin
            m_nxt_ce = 1'b1;
            m_tc = cyc_no + 32;
          end
        end
      end
      m_ce = m_nxt_ce;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("state", int'(state), m_mode);
      chk("cpu_rst", int'(cpu_rst), int'(m_mode == 0));
      chk("ce", int'(ce), int'(m_ce && !halt));
      chk("bp_hit", int'(bp_hit), int'(m_bp));
      chk("retired", int'(retired), m_ret);
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_run();
    run = 1'b1; align(); run = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1; align(); step = 1'b0;
  endtask

  task automatic pulse_halt();
    halt = 1'b1; align(); halt = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; halt = 1'b0; step = 1'b0;
    repeat (3) align();
    rst = 1'b0;
    repeat (6) align();
  endtask

  task automatic wait_state(input int s, input int budget);
    int k;
    k = 0;
    while (int'(state) != s && k < budget) begin
      align();
      k++;
    end
    chk("wait_state", int'(state), s);
  endtask

  initial begin
    int n;
    int k;
    bit found;

    #2 rst = 1'b1;
    #1 chk_on = 1'b1;
    repeat (3) align();
    chk("rst_state", int'(state), 0);
    chk("rst_cpu_rst", int'(cpu_rst), 1);
    chk("rst_ce", int'(ce), 0);
    chk("rst_retired", int'(retired), 0);

    // reset hold length and idle halted state
    rst = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_rst) n++;
    end
    chk("rst_hold_cycles", n, 4);
    chk("after_hold_state", int'(state), 1);
    n = 0;
    repeat (200) begin
      @(negedge clk);
      if (ce) n++;
    end
    chk("idle_ce_count", n, 0);
    align();

    // single step latency
    pulse_step();
    k = 0; found = 1'b0;
    while (!found && k < 100) begin
      @(posedge clk);
      k++;
      #1;
      if (ce) found = 1'b1;
    end
    chk("step_latency", k, 32);
    n = 0;
    repeat (100) begin
      align();
      if (ce) n++;
    end
    chk("step_extra_ce", n, 0);
    chk("step_state", int'(state), 1);
    chk("step_retired", int'(retired), 1);

    // breakpoint at PC 5, then resume over it
    do_reset();
    bp_en = 1'b1; bp_addr = 8'h05; instr_mode = 0;
    pulse_run();
    wait_state(1, 400);
    chk("bp_retired", int'(retired), 5);
    chk("bp_hit", int'(bp_hit), 1);
    chk("bp_pc", int'(pc), 5);
    pulse_run();
    chk("bp_hit_cleared", int'(bp_hit), 0);
    repeat (40) align();
    chk("resume_retired", int'(retired), 6);
    chk("resume_pc", int'(pc), 6);
    chk("resume_state", int'(state), 2);
    pulse_halt();
    chk("halt_state", int'(state), 1);
    bp_en = 1'b0;

    // HLT opcode at PC 3
    do_reset();
    instr_mode = 1;
    pulse_run();
    wait_state(1, 300);
    chk("hlt_retired", int'(retired), 3);
    chk("hlt_pc", int'(pc), 3);
    pulse_step();
    n = 0;
    repeat (40) begin
      align();
      if (ce) n++;
    end
    chk("hlt_step_ce", n, 0);
    chk("hlt_step_state", int'(state), 1);
    instr_mode = 0;

    // HALT + STEP together in the enable cycle
    do_reset();
    pulse_run();
    repeat (32) @(posedge clk);
    #1;
    chk("tc_ce_pre", int'(ce), 1);
    halt = 1'b1; step = 1'b1;
    #1;
    chk("tc_ce_masked", int'(ce), 0);
    align();
    halt = 1'b0; step = 1'b0;
    chk("tc_halt_state", int'(state), 1);
    chk("tc_halt_retired", int'(retired), 0);

    // reset mid-run with divider at 17
    do_reset();
    pulse_run();
    repeat (81) @(posedge clk);
    #1;
    chk("midrun_retired", int'(retired), 2);
    rst = 1'b1;
    #1;
    chk("midrun_ce", int'(ce), 0);
    chk("midrun_cpu_rst", int'(cpu_rst), 1);
    chk("midrun_retired0", int'(retired), 0);
    chk("midrun_state", int'(state), 0);
    repeat (2) align();
    rst = 1'b0;
    repeat (6) align();

    // randomized traffic against the model
    instr_mode = 2;
    for (int i = 0; i < 6000; i++) begin
      run  = ($urandom % 24 == 0);
      step = ($urandom % 24 == 0);
      halt = ($urandom % 50 == 0);
      instr_rand = 16'($urandom);
      if ($urandom % 150 == 0) begin
        bp_en = 1'($urandom % 2);
        bp_addr = pc + 8'($urandom % 3);
      end
      rst = ($urandom % 1500 == 0);
      align();
    end
    run = 1'b0; step = 1'b0; halt = 1'b0; rst = 1'b0;
    repeat (4) align();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_step_controller.md
Name: cpu_step_controller

Overview:
- Run/halt/single-step sequencer for the microcontroller core.
- Runs on the fast memory-side clock and issues a one-cycle clock enable to the core every 2^DIV_LOG2 cycles, replacing ad-hoc divided clocks.
- Holds the core in reset after power-up, and stops on a PC breakpoint or a HLT instruction.
- Sits between the board-level control inputs (buttons/debug) and the core's clock-enable and reset.

Parameters:
- DIV_LOG2, 5: enable period is 2^DIV_LOG2 clock cycles (32).
- PC_W, 8: program counter width.
- INSTR_W, 16: instruction width.
- HLT_OPCODE, 4'hF: value of i_INSTR[INSTR_W-1 -: 4] that halts execution.
- RST_HOLD, 4: cycles o_CPU_RST stays asserted after reset release.
- AUTO_RUN, 0: 1 means go to RUNNING, not HALTED, after reset hold.

Ports:
- i_CLK  in  1  single clock (memory-rate clock).
- i_RST  in  1  asynchronous, active-high reset.
- i_RUN  in  1  one-cycle pulse: enter free-run.
- i_HALT  in  1  one-cycle pulse: stop.
- i_STEP  in  1  one-cycle pulse: execute exactly one instruction.
- i_BP_EN  in  1  breakpoint enable.
- i_BP_ADDR  in  PC_W  breakpoint address.
- i_PC  in  PC_W  current core PC.
- i_INSTR  in  INSTR_W  current core instruction.
- o_CPU_CE  out  1  one-cycle core clock enable.
- o_CPU_RST  out  1  core reset, active-high.
- o_STATE  out  2  00 RESET_HOLD, 01 HALTED, 10 RUNNING, 11 STEPPING.
- o_BP_HIT  out  1  sticky breakpoint flag.
- o_RETIRED  out  16  count of issued enables.

Behaviour:
- Reset values (asynchronous, while i_RST=1):
  - state=RESET_HOLD, o_CPU_RST=1, o_CPU_CE=0, o_BP_HIT=0, o_RETIRED=0.
  - Divider=0, hold counter=0, resume flag=0.
- RESET_HOLD:
  - o_CPU_RST=1 for RST_HOLD cycles after i_RST falls.
  - Then go to HALTED, or RUNNING if AUTO_RUN=1.
  - All pulse inputs are ignored in this state.
- HALTED:
  - Divider held at 0; o_CPU_CE=0.
  - i_RUN → RUNNING; i_STEP → STEPPING.
  - Both transitions set the resume flag and clear o_BP_HIT.
- RUNNING/STEPPING divider:
  - Counts 0..2^DIV_LOG2-1.
  - Terminal count (TC) is reached 2^DIV_LOG2 cycles after entry.
- Checks at TC, in this order:
  - a) Opcode field == HLT_OPCODE → HALTED, no CE.
  - b) i_BP_EN && i_PC==i_BP_ADDR && resume flag==0 → HALTED, no CE, o_BP_HIT=1.
  - c) Otherwise o_CPU_CE=1 for that single cycle; o_RETIRED increments, saturating at 16'hFFFF; resume flag cleared.
- After a CE:
  - STEPPING → HALTED.
  - RUNNING → divider wraps to 0 and continues.
- Input priority in the same cycle: i_HALT > i_STEP > i_RUN.
- i_HALT in RUNNING/STEPPING:
  - → HALTED next edge, divider cleared.
  - No CE is issued, even if that cycle is TC; the HALT combinationally masks CE.
- Ignored inputs:
  - i_RUN and i_STEP while RUNNING/STEPPING.
  - i_HALT while HALTED.
- Resume flag: guarantees that resuming from a breakpoint executes the breakpointed instruction.
- o_CPU_CE is registered except for the HALT mask above; it is never high two consecutive cycles.
- Reset mid-operation: outputs return to reset values immediately (asynchronously); any partial divider count is discarded.

Optional Feature:
- Macro: STEP_CTRL_TRACE_EN.
- Defined: adds ports o_LAST_PC (PC_W) and o_TRACE_VLD (1).
  - o_LAST_PC latches i_PC on every CE.
  - o_TRACE_VLD pulses one cycle after each CE.
  - Both reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state encoding constants ST_RESET_HOLD/ST_HALTED/ST_RUNNING/ST_STEPPING.
  - HLT opcode default.
  - opcode field width (4).
  - o_RETIRED width (16).
- One sub-module, ce_divider:
  - Parameterised DIV_LOG2 counter with synchronous clear and enable.
  - Outputs a TC flag.
  - Async active-high reset.

Test Plan:
- Release i_RST → o_CPU_RST=1 for exactly 4 cycles; state HALTED; no o_CPU_CE over 200 cycles.
- HALTED, i_STEP pulse at cycle t → single o_CPU_CE at t+32; state back to HALTED; o_RETIRED=1.
- Core model increments PC on CE from 0; BP_EN=1, BP_ADDR=8'h05; i_RUN:
  - 5 CEs (PC 0..4) occur, then HALTED, o_BP_HIT=1, o_RETIRED=5.
  - A further i_RUN issues a CE at PC 5 and continues running.
- RUNNING with i_INSTR=16'hF000 at PC 3 → halts at that TC without CE; o_RETIRED=3; a subsequent i_STEP yields no CE.
- RUNNING, i_HALT and i_STEP pulsed together on a TC cycle → o_CPU_CE stays 0; state HALTED next edge.
- Assert i_RST while RUNNING with divider=17 → o_CPU_CE=0, o_CPU_RST=1, o_RETIRED=0 before the next clock edge.
